// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y counters, sync/blank decode, registered event strobes, frame counter.
// Latency: x/y/strobes are registered (1 clk); hsync/vsync/blank decode combinationally from x/y.
// Backpressure: none; the raster advances only on pix_en edges and holds otherwise.
module vga_timing_gen #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int HFRONT     = 16,
    parameter int HSYNC      = 96,
    parameter int HBACK      = 48,
    parameter int VFRONT     = 10,
    parameter int VSYNC      = 2,
    parameter int VBACK      = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int FRAME_BITS = 8,
    localparam int HTOTAL    = WIDTH + HFRONT + HSYNC + HBACK,
    localparam int VTOTAL    = HEIGHT + VFRONT + VSYNC + VBACK,
    localparam int XW        = $clog2(HTOTAL),
    localparam int YW        = $clog2(VTOTAL)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    input  logic [YW-1:0]         line_cmp,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  vsync_pulse,
    output logic                  line_irq,
    output logic [FRAME_BITS-1:0] frame_count
);

    // HTOTAL/VTOTAL may be a power of two and not fit XW/YW, so only last-index constants are used.
    localparam logic [XW-1:0] X_LAST   = XW'(HTOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(WIDTH);
    localparam logic [XW-1:0] HS_START = XW'(WIDTH + HFRONT);
    localparam logic [XW-1:0] HS_END   = XW'(WIDTH + HFRONT + HSYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(VTOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(HEIGHT);
    localparam logic [YW-1:0] VS_START = YW'(HEIGHT + VFRONT);
    localparam logic [YW-1:0] VS_END   = YW'(HEIGHT + VFRONT + VSYNC);

    logic [YW-1:0] cmp_shadow;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic [YW-1:0] irq_line;
    logic          x_wrap;
    logic          new_frame;
    logic          hs_act;
    logic          vs_act;

    always_comb begin
        x_wrap    = (x == X_LAST);
        new_frame = x_wrap && (y == Y_LAST);
        x_nxt     = x_wrap ? '0 : x + 1'b1;
        y_nxt     = y;
        if (x_wrap) begin
            y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
        end
        // The shadow reloads on the frame_start edge, so line 0 compares against the fresh value.
        irq_line = new_frame ? line_cmp : cmp_shadow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            cmp_shadow  <= line_cmp;
            frame_count <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vsync_pulse <= 1'b0;
            line_irq    <= 1'b0;
        end else begin
            line_start  <= pix_en && x_wrap;
            frame_start <= pix_en && new_frame;
            vsync_pulse <= pix_en && x_wrap && (y_nxt == VS_START);
            line_irq    <= pix_en && x_wrap && (y_nxt == irq_line);
            if (pix_en) begin
                x <= x_nxt;
                y <= y_nxt;
                if (new_frame) begin
                    cmp_shadow  <= line_cmp;
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hs_act = (x >= HS_START) && (x < HS_END);
        vs_act = (y >= VS_START) && (y < VS_END);
        hsync  = hs_act ^ ~HSYNC_POL;
        vsync  = vs_act ^ ~VSYNC_POL;
        blank  = (x >= X_ACT) || (y >= Y_ACT);
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for horizontal checks, small-timing instances
// (active-low and active-high sync) for vertical, strobe, irq, wrap and reset checks.
module tb_vga_timing_gen;

    localparam int S_HT = 14;  // 8+2+3+1
    localparam int S_FR = 140; // 14 * (6+1+2+1)

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_en = 1'b0;
    logic [9:0] lc_d = '0;
    logic [3:0] lc_s = '0;

    logic [9:0] x_d, y_d;
    logic       hs_d, vs_d, bl_d, ls_d, fs_d, vp_d, irq_d;
    logic [7:0] fc_d;
    logic [3:0] x_s, y_s;
    logic       hs_s, vs_s, bl_s, ls_s, fs_s, vp_s, irq_s;
    logic [7:0] fc_s;
    logic [3:0] x_p, y_p;
    logic       hs_p, vs_p, bl_p, ls_p, fs_p, vp_p, irq_p;
    logic [7:0] fc_p;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_d (
        .clk(clk), .reset(reset), .pix_en(pix_en), .line_cmp(lc_d),
        .x(x_d), .y(y_d), .hsync(hs_d), .vsync(vs_d), .blank(bl_d),
        .line_start(ls_d), .frame_start(fs_d), .vsync_pulse(vp_d),
        .line_irq(irq_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .WIDTH(8), .HEIGHT(6), .HFRONT(2), .HSYNC(3), .HBACK(1),
        .VFRONT(1), .VSYNC(2), .VBACK(1)
    ) u_dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en), .line_cmp(lc_s),
        .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s), .blank(bl_s),
        .line_start(ls_s), .frame_start(fs_s), .vsync_pulse(vp_s),
        .line_irq(irq_s), .frame_count(fc_s)
    );

    vga_timing_gen #(
        .WIDTH(8), .HEIGHT(6), .HFRONT(2), .HSYNC(3), .HBACK(1),
        .VFRONT(1), .VSYNC(2), .VBACK(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_dut_p (
        .clk(clk), .reset(reset), .pix_en(pix_en), .line_cmp(lc_s),
        .x(x_p), .y(y_p), .hsync(hs_p), .vsync(vs_p), .blank(bl_p),
        .line_start(ls_p), .frame_start(fs_p), .vsync_pulse(vp_p),
        .line_irq(irq_p), .frame_count(fc_p)
    );

    // Leaves every counter at (0,0) with reset released; the next posedge is raster step 1.
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        pix_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (x_d !== 10'd0 || y_d !== 10'd0) begin
            errors++; $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", x_d, y_d);
        end
        vectors++;
        if ({hs_d, vs_d, bl_d} !== 3'b110) begin
            errors++; $display("FAIL reset_sync_blank: got %b, want 110", {hs_d, vs_d, bl_d});
        end
        vectors++;
        if ({ls_d, fs_d, vp_d, irq_d, ls_s, fs_s, vp_s, irq_s} !== 8'd0 || fc_d !== 8'd0) begin
            errors++;
            $display("FAIL reset_strobes: got %b fc=%0d, want 0 0",
                     {ls_d, fs_d, vp_d, irq_d, ls_s, fs_s, vp_s, irq_s}, fc_d);
        end
        vectors++;
        if ({hs_p, vs_p} !== 2'b00) begin
            errors++; $display("FAIL reset_pol: got %b, want 00", {hs_p, vs_p});
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (x_d !== 10'd5 || y_d !== 10'd0) begin
            errors++; $display("FAIL reset_release_inc: got x=%0d y=%0d, want 5 0", x_d, y_d);
        end
    endtask

    task automatic test_default_horizontal();
        int   hs_low = 0, fall1 = -1, fall2 = -1, bl_low = 0, ls_cnt = 0, irq_n = -1;
        logic prev_hs = 1'b1;
        lc_d = 10'd2;
        do_reset();
        for (int n = 1; n <= 1600; n++) begin
            @(negedge clk);
            if (!hs_d) hs_low++;
            if (prev_hs && !hs_d) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            prev_hs = hs_d;
            if (n <= 800 && !bl_d) bl_low++;
            if (ls_d) ls_cnt++;
            if (irq_d && irq_n < 0) irq_n = n;
        end
        vectors++;
        if (fall1 !== 656) begin
            errors++; $display("FAIL hsync_start: got %0d, want 656", fall1);
        end
        vectors++;
        if (fall2 - fall1 !== 800) begin
            errors++; $display("FAIL hsync_period: got %0d, want 800", fall2 - fall1);
        end
        vectors++;
        if (hs_low !== 192) begin
            errors++; $display("FAIL hsync_width: got %0d, want 192", hs_low);
        end
        vectors++;
        if (bl_low !== 640) begin
            errors++; $display("FAIL blank_active: got %0d, want 640", bl_low);
        end
        vectors++;
        if (ls_cnt !== 2) begin
            errors++; $display("FAIL line_start_cnt: got %0d, want 2", ls_cnt);
        end
        vectors++;
        if (irq_n !== 1600) begin
            errors++; $display("FAIL default_irq: got %0d, want 1600", irq_n);
        end
    endtask

    task automatic test_small_frame();
        int vs_low = 0, vs_first = -1, vp_cnt = 0, vp_bad = 0, fs_cnt = 0, bl_low = 0;
        int hp_high = 0, pol_bad = 0;
        do_reset();
        for (int n = 1; n <= 2 * S_FR; n++) begin
            @(negedge clk);
            if (!vs_s) vs_low++;
            if (!vs_s && vs_first < 0) vs_first = n;
            if (vp_s) begin
                vp_cnt++;
                if (x_s !== 4'd0 || y_s !== 4'd7) vp_bad++;
            end
            if (fs_s && (n % S_FR) == 0) fs_cnt++;
            if (!bl_s) bl_low++;
            if (hs_p) hp_high++;
            if (hs_p !== ~hs_s || vs_p !== ~vs_s) pol_bad++;
        end
        vectors++;
        if (vs_first !== 98 || vs_low !== 56) begin
            errors++; $display("FAIL vsync_timing: got start=%0d low=%0d, want 98 56", vs_first, vs_low);
        end
        vectors++;
        if (vp_cnt !== 2 || vp_bad !== 0) begin
            errors++; $display("FAIL vsync_pulse: got cnt=%0d bad=%0d, want 2 0", vp_cnt, vp_bad);
        end
        vectors++;
        if (fs_cnt !== 2 || fc_s !== 8'd2) begin
            errors++; $display("FAIL frame_start: got cnt=%0d fc=%0d, want 2 2", fs_cnt, fc_s);
        end
        vectors++;
        if (bl_low !== 96) begin
            errors++; $display("FAIL small_blank: got %0d, want 96", bl_low);
        end
        vectors++;
        if (hp_high !== 60 || pol_bad !== 0) begin
            errors++; $display("FAIL sync_polarity: got high=%0d bad=%0d, want 60 0", hp_high, pol_bad);
        end
    endtask

    task automatic test_sparse_pix_en();
        int         hold_bad = 0, wide_bad = 0, run = 0, first_run = -1, fs1 = -1, fs2 = -1;
        logic [3:0] prev_x;
        lc_s = 4'd3;
        do_reset();
        for (int i = 0; i < 4 * S_FR; i++) begin
            pix_en = (i % 2 == 0);
            prev_x = x_s;
            @(negedge clk);
            if (!pix_en && x_s !== prev_x) hold_bad++;
            if (!pix_en && (ls_s || fs_s || vp_s || irq_s)) wide_bad++;
            if (!hs_s) run++;
            else begin
                if (run > 0 && first_run < 0) first_run = run;
                run = 0;
            end
            if (fs_s) begin
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
        end
        pix_en = 1'b1;
        vectors++;
        if (hold_bad !== 0) begin
            errors++; $display("FAIL sparse_hold: got %0d, want 0", hold_bad);
        end
        vectors++;
        if (wide_bad !== 0) begin
            errors++; $display("FAIL sparse_strobe_width: got %0d, want 0", wide_bad);
        end
        vectors++;
        if (first_run !== 6) begin
            errors++; $display("FAIL sparse_hsync_width: got %0d, want 6", first_run);
        end
        vectors++;
        if (fs1 !== 278 || fs2 - fs1 !== 280) begin
            errors++; $display("FAIL sparse_frame_period: got fs1=%0d period=%0d, want 278 280", fs1, fs2 - fs1);
        end
    endtask

    task automatic test_line_irq();
        int irq1 = -1, irq2 = -1, cnt = 0, coinc = 0, bad = 0;
        lc_s = 4'd3;
        do_reset();
        for (int n = 1; n <= 2 * S_FR; n++) begin
            @(negedge clk);
            if (irq_s) begin
                cnt++;
                if (irq1 < 0) irq1 = n; else irq2 = n;
                if (x_s !== 4'd0) bad++;
            end
            if (n == S_HT) lc_s = 4'd5;
        end
        vectors++;
        if (cnt !== 2 || irq1 !== 42 || irq2 !== 210 || bad !== 0) begin
            errors++;
            $display("FAIL irq_reload: got cnt=%0d at %0d,%0d bad=%0d, want 2 at 42,210 bad=0", cnt, irq1, irq2, bad);
        end

        lc_s = 4'd0;
        cnt = 0;
        do_reset();
        for (int n = 1; n <= 2 * S_FR; n++) begin
            @(negedge clk);
            if (irq_s) cnt++;
            if (irq_s && fs_s) coinc++;
        end
        vectors++;
        if (cnt !== 2 || coinc !== 2) begin
            errors++; $display("FAIL irq_zero: got cnt=%0d coinc=%0d, want 2 2", cnt, coinc);
        end

        lc_s = 4'd12;
        cnt = 0;
        do_reset();
        for (int n = 1; n <= 2 * S_FR; n++) begin
            @(negedge clk);
            if (irq_s) cnt++;
        end
        vectors++;
        if (cnt !== 0) begin
            errors++; $display("FAIL irq_out_of_range: got %0d, want 0", cnt);
        end
    endtask

    task automatic test_frame_wrap();
        do_reset();
        for (int n = 1; n <= 257 * S_FR; n++) begin
            @(negedge clk);
            if (n == 255 * S_FR) begin
                vectors++;
                if (fc_s !== 8'd255) begin
                    errors++; $display("FAIL frame_count_255: got %0d, want 255", fc_s);
                end
            end
            if (n == 256 * S_FR) begin
                vectors++;
                if (fc_s !== 8'd0) begin
                    errors++; $display("FAIL frame_count_wrap: got %0d, want 0", fc_s);
                end
            end
            if (n == 257 * S_FR) begin
                vectors++;
                if (fc_s !== 8'd1) begin
                    errors++; $display("FAIL frame_count_after_wrap: got %0d, want 1", fc_s);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int fs_cnt = 0, fs_first = -1;
        lc_s = 4'd3;
        do_reset();
        repeat (S_FR + 4 * S_HT + 5) @(negedge clk);
        vectors++;
        if (x_s !== 4'd5 || y_s !== 4'd4 || fc_s !== 8'd1) begin
            errors++; $display("FAIL pre_reset_pos: got x=%0d y=%0d fc=%0d, want 5 4 1", x_s, y_s, fc_s);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (x_s !== 4'd0 || y_s !== 4'd0 || fc_s !== 8'd0 || x_d !== 10'd0 || y_d !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_pos: got x=%0d y=%0d fc=%0d xd=%0d yd=%0d, want all 0", x_s, y_s, fc_s, x_d, y_d);
        end
        vectors++;
        if ({ls_s, fs_s, vp_s, irq_s} !== 4'd0) begin
            errors++; $display("FAIL mid_reset_strobes: got %b, want 0000", {ls_s, fs_s, vp_s, irq_s});
        end
        for (int n = 1; n <= S_FR; n++) begin
            @(negedge clk);
            if (fs_s) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
            end
        end
        vectors++;
        if (fs_cnt !== 1 || fs_first !== S_FR) begin
            errors++; $display("FAIL post_reset_frame: got cnt=%0d at %0d, want 1 at 140", fs_cnt, fs_first);
        end
    endtask

    initial begin
        test_reset();
        test_default_horizontal();
        test_small_frame();
        test_sparse_pix_en();
        test_line_irq();
        test_frame_wrap();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
